// File: rtl/mem_interface_if.sv
// Bundle of the datapath, control-unit and RAM signals handled by the memory interface stage.
// The slave modport is the stage itself. The master modport is its environment.
interface mem_interface_if #(
    parameter int ADDR_W = 9
);
    logic              mar_in;
    logic [31:0]       bus;
    logic [31:0]       mdr_data;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic [31:0]       data_in;
    logic              mdr_read;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  mar_in, bus, mdr_data, read, write, mem_rdata,
        output mem_addr, mem_wdata, mem_re, mem_we, data_in, mdr_read, busy, done, err
    );

    modport master (
        output mar_in, bus, mdr_data, read, write, mem_rdata,
        input  mem_addr, mem_wdata, mem_re, mem_we, data_in, mdr_read, busy, done, err
    );
endinterface

// File: rtl/mem_interface.sv
// Memory interface stage: holds MAR and sequences fixed-latency reads and writes to the single-port RAM.
// Every output comes from a register, so there is no combinational path from an input to an output.
module mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input logic          clk,
    input logic          clr,
    mem_interface_if.slave mif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
    localparam logic [2:0] FIN_RD = 3'd3;
    localparam logic [2:0] FIN_WR = 3'd4;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [2:0]  state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] mar_r, mar_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] rdata_r, rdata_s;
    logic        err_r, err_s;
    logic        mem_re_r, mem_we_r, done_r, mdr_read_r, busy_r;
    logic        addr_bad_s;

    // The range check uses the MAR value held before this edge, because a same-cycle mar_in cannot affect the request.
    always_comb begin
        addr_bad_s = ((mar_r >> ADDR_W) != 32'd0);
    end

    // Next-state logic. Requests and mar_in are sampled only in IDLE.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mar_s   = mar_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mif.mar_in) begin
                    mar_s = mif.bus;
                end else begin
                    mar_s = mar_r;
                end
                if (mif.read && mif.write) begin
                    err_s = 1'b1;
                end else if ((mif.read || mif.write) && addr_bad_s) begin
                    err_s = 1'b1;
                end else if (mif.read) begin
                    state_s = RD;
                    cnt_s   = LAT_M1;
                end else if (mif.write) begin
                    state_s = WR;
                    cnt_s   = LAT_M1;
                    wdata_s = mif.mdr_data;
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (cnt_r == 4'd0) begin
                    rdata_s = mif.mem_rdata;
                    state_s = FIN_RD;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            WR: begin
                if (cnt_r == 4'd0) begin
                    state_s = FIN_WR;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            FIN_RD:  state_s = IDLE;
            FIN_WR:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            mar_r   <= 32'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            mar_r   <= mar_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
        end
    end

    // Strobes are registered from the next state. The write strobe covers only the first WR cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mem_re_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            done_r     <= 1'b0;
            mdr_read_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            mem_re_r   <= (state_s == RD);
            mem_we_r   <= (state_s == WR) && (cnt_s == LAT_M1);
            done_r     <= (state_s == FIN_RD) || (state_s == FIN_WR);
            mdr_read_r <= (state_s == FIN_RD);
            busy_r     <= (state_s != IDLE);
        end
    end

    assign mif.mem_addr  = mar_r[ADDR_W-1:0];
    assign mif.mem_wdata = wdata_r;
    assign mif.mem_re    = mem_re_r;
    assign mif.mem_we    = mem_we_r;
    assign mif.data_in   = rdata_r;
    assign mif.mdr_read  = mdr_read_r;
    assign mif.busy      = busy_r;
    assign mif.done      = done_r;
    assign mif.err       = err_r;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: a latency-aware RAM model plus a transaction-level reference model,
// driven by directed steps and then by randomized accesses.
module tb_mem_interface;

    localparam int AW  = 9;
    localparam int LAT = 2;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    mem_interface_if #(.ADDR_W(AW)) mif ();

    mem_interface #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk (clk),
        .clr (clr),
        .mif (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words hold a fixed pattern. Address 0x054 holds 0xA5.
    function automatic logic [31:0] seed_fn(input logic [AW-1:0] a);
        logic [31:0] v;
        if (a == 9'h054) begin
            v = 32'h0000_00A5;
        end else begin
            v = (32'h9E37_79B9 * {23'd0, a}) ^ 32'h5A5A_0000;
        end
        return v;
    endfunction

    // The RAM model returns valid data only in the LATENCY-th cycle of mem_re.
    logic [31:0] ram       [512];
    bit          ram_valid [512];
    int          re_cnt;
    logic [31:0] ram_word;

    always @(posedge clk) begin
        if (mif.mem_we) begin
            ram[mif.mem_addr]       <= mif.mem_wdata;
            ram_valid[mif.mem_addr] <= 1'b1;
        end
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            re_cnt <= 0;
        end else if (mif.mem_re) begin
            re_cnt <= re_cnt + 1;
        end else begin
            re_cnt <= 0;
        end
    end

    assign ram_word      = ram_valid[mif.mem_addr] ? ram[mif.mem_addr] : seed_fn(mif.mem_addr);
    assign mif.mem_rdata = (mif.mem_re && (re_cnt == LAT - 1)) ? ram_word : 32'hBAD0_BAD0;

    // The reference model keeps its own copy of memory, the MAR and the last read value.
    logic [31:0] ref_mem   [512];
    bit          ref_valid [512];
    logic [31:0] model_mar;
    logic [31:0] model_data;

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        return ref_valid[a] ? ref_mem[a] : seed_fn(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, mif.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, mif.done}, 32'd0);
        chk({tag, "_mdr_read"}, {31'd0, mif.mdr_read}, 32'd0);
        chk({tag, "_mem_re"}, {31'd0, mif.mem_re}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mif.mem_we}, 32'd0);
        chk({tag, "_data_in"}, mif.data_in, model_data);
        chk({tag, "_mem_addr"}, {23'd0, mif.mem_addr}, {23'd0, model_mar[AW-1:0]});
    endtask

    // Loads MAR, then issues one request. junk: 0 = quiet while busy, 1 = write+mar_in(0x10), 2 = random.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int junk);
        logic        reject;
        logic [31:0] exp_rd;
        mif.bus    = addr;
        mif.mar_in = 1'b1;
        mif.read   = 1'b0;
        mif.write  = 1'b0;
        @(negedge clk);
        model_mar  = addr;
        mif.mar_in = 1'b0;
        chk("mar_load", {23'd0, mif.mem_addr}, {23'd0, model_mar[AW-1:0]});
        chk("pre_busy", {31'd0, mif.busy}, 32'd0);
        mif.mdr_data = wd;
        mif.read     = rd;
        mif.write    = wr;
        reject = (rd && wr) || ((rd || wr) && (addr >= 32'd512));
        exp_rd = ref_rd(addr[AW-1:0]);
        @(negedge clk);
        mif.read  = 1'b0;
        mif.write = 1'b0;
        if (reject) begin
            chk("rej_err", {31'd0, mif.err}, 32'd1);
            chk_idle("rej");
            @(negedge clk);
            chk("rej_err_clear", {31'd0, mif.err}, 32'd0);
            chk_idle("rej_after");
        end else if (rd || wr) begin
            for (int i = 0; i <= LAT; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                end
                chk("acc_busy", {31'd0, mif.busy}, 32'd1);
                chk("acc_err", {31'd0, mif.err}, 32'd0);
                chk("acc_mem_re", {31'd0, mif.mem_re}, {31'd0, rd && (i < LAT)});
                chk("acc_mem_we", {31'd0, mif.mem_we}, {31'd0, wr && (i == 0)});
                chk("acc_done", {31'd0, mif.done}, {31'd0, i == LAT});
                chk("acc_mdr_read", {31'd0, mif.mdr_read}, {31'd0, rd && (i == LAT)});
                chk("acc_mem_addr", {23'd0, mif.mem_addr}, {23'd0, model_mar[AW-1:0]});
                chk("acc_data_in", mif.data_in, (rd && (i == LAT)) ? exp_rd : model_data);
                if (wr) begin
                    chk("acc_mem_wdata", mif.mem_wdata, wd);
                end
                if (i < LAT && junk == 1) begin
                    mif.write  = 1'b1;
                    mif.mar_in = 1'b1;
                    mif.bus    = 32'h0000_0010;
                end else if (i < LAT && junk == 2) begin
                    mif.read     = 1'($urandom_range(0, 1));
                    mif.write    = 1'($urandom_range(0, 1));
                    mif.mar_in   = 1'($urandom_range(0, 1));
                    mif.bus      = $urandom;
                    mif.mdr_data = $urandom;
                end else begin
                    mif.read   = 1'b0;
                    mif.write  = 1'b0;
                    mif.mar_in = 1'b0;
                end
            end
            if (rd) begin
                model_data = exp_rd;
            end
            if (wr) begin
                ref_mem[addr[AW-1:0]]   = wd;
                ref_valid[addr[AW-1:0]] = 1'b1;
            end
            @(negedge clk);
            chk("post_err", {31'd0, mif.err}, 32'd0);
            chk_idle("post");
        end else begin
            chk("none_err", {31'd0, mif.err}, 32'd0);
            chk_idle("none");
        end
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        checks       = 0;
        errors       = 0;
        model_mar    = 32'd0;
        model_data   = 32'd0;
        clr          = 1'b1;
        mif.mar_in   = 1'b0;
        mif.bus      = 32'd0;
        mif.mdr_data = 32'd0;
        mif.read     = 1'b0;
        mif.write    = 1'b0;
        #3;
        chk("rst_err", {31'd0, mif.err}, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk_idle("rst");
        @(negedge clk);
        clr = 1'b0;

        // Directed read: RAM holds 0xA5 at 0x054.
        do_access(1'b1, 1'b0, 32'h0000_0054, 32'd0, 0);
        chk("rd_a5", mif.data_in, 32'h0000_00A5);
        // Write, then read back.
        do_access(1'b0, 1'b1, 32'h0000_01F0, 32'hDEAD_BEEF, 0);
        chk("wr_keeps_data_in", mif.data_in, 32'h0000_00A5);
        do_access(1'b1, 1'b0, 32'h0000_01F0, 32'd0, 0);
        chk("rd_back", mif.data_in, 32'hDEAD_BEEF);
        // Requests made while busy are ignored.
        do_access(1'b1, 1'b0, 32'h0000_0054, 32'd0, 1);
        // Error cases: both requests together, then an out-of-range MAR.
        do_access(1'b1, 1'b1, 32'h0000_0054, 32'h1234_5678, 0);
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'd0, 0);
        do_access(1'b0, 1'b1, 32'h8000_0003, 32'h1111_2222, 0);

        // Reset asserted in the middle of a read.
        mif.bus    = 32'h0000_0077;
        mif.mar_in = 1'b1;
        @(negedge clk);
        mif.mar_in = 1'b0;
        mif.read   = 1'b1;
        @(negedge clk);
        mif.read = 1'b0;
        chk("midrst_re_before", {31'd0, mif.mem_re}, 32'd1);
        #2;
        clr = 1'b1;
        #1;
        model_mar  = 32'd0;
        model_data = 32'd0;
        chk("midrst_err", {31'd0, mif.err}, 32'd0);
        chk_idle("midrst");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk_idle("midrst_after");
        do_access(1'b1, 1'b0, 32'h0000_0054, 32'd0, 0);
        chk("rd_after_rst", mif.data_in, 32'h0000_00A5);

        // Randomized accesses, with addresses concentrated in a small window so that reads hit earlier writes.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom & 32'h0000_01FF;
            end else begin
                a = a;
            end
            if (kind == 0) begin
                do_access(1'b1, 1'b1, a, $urandom, 2);
            end else if (kind == 1) begin
                do_access(1'($urandom_range(0, 1)), 1'b0, a | 32'h0000_0200, $urandom, 2);
            end else if (kind == 2) begin
                do_access(1'b0, 1'b0, a, $urandom, 0);
            end else if (kind < 6) begin
                do_access(1'b0, 1'b1, a, $urandom, 2);
            end else begin
                do_access(1'b1, 1'b0, a, $urandom, 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
